quad_enc_gen: RTL and testbench

Quadrature encoder signal generator: on a start command it emits a commanded number of quadrature edges on A/B at a programmable rate and direction. It is the transmitting end of the motor-encoder path. Its A/B outputs drive the encoder counter block in simulation and bring-up, standing in for a physical motor encoder. It also keeps an internal position count that the counter's result is checked against.

---
 rtl/quad_enc_gen_pkg.sv | 16 +
 rtl/quad_enc_gen_rate_div.sv | 38 +++
 rtl/quad_enc_gen.sv | 153 +++++++++++++++
 tb/tb_quad_enc_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_enc_gen_pkg.sv
// Shared types and defaults for the quadrature encoder generator.
package quad_enc_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned DIV_W_DEF = 16;
  localparam int unsigned CPR_DEF   = 64;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // Phase index to {A,B}: 0->00, 1->10, 2->11, 3->01 (Gray sequence).
  localparam logic [3:0][1:0] PHASE_AB = {2'b01, 2'b11, 2'b10, 2'b00};

endpackage

// File: rtl/quad_enc_gen_rate_div.sv
// Loadable edge-rate divider: counts 0..P-1 and pulses o_tc on the terminal count.
module rate_div
  import quad_enc_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_period,
  input  logic             i_clr,
  input  logic             i_en,
  output logic             o_tc
);

  logic [DIV_W-1:0] r_term;
  logic [DIV_W-1:0] r_cnt;
  logic             w_at_term;

  assign w_at_term = (r_cnt == r_term);
  assign o_tc      = i_en & w_at_term;

  // A period of 0 collapses onto the same terminal value as a period of 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_term <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_term <= (i_period == '0) ? '0 : i_period - 1'b1;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_term ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature encoder generator: emits a commanded number of A/B edges at a set rate.
// Optional index output enc_z and revolution counter enabled by `ENC_INDEX_EN.
module quad_enc_gen
  import quad_enc_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned CPR   = CPR_DEF
) (
  input  logic             cloc,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] period,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             enc_a,
  output logic             enc_b,
  output logic [CNT_W-1:0] pos
`ifdef ENC_INDEX_EN
  ,
  output logic             enc_z
`endif
);

  if (CPR < 2) begin : g_cpr_chk
    $error("quad_enc_gen: CPR must be at least 2");
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_done_nxt;
  logic             r_done;
  logic             r_dir;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_pos;
  logic [1:0]       r_phase;
  logic [1:0]       w_phase_nxt;
  logic             r_a;
  logic             r_b;
  logic             w_accept;
  logic             w_run;
  logic             w_edge;
  logic             w_last;

  assign w_run       = (r_state == RUN);
  assign w_accept    = (r_state == IDLE) && start && (steps != '0);
  assign w_last      = w_edge && (r_remaining == CNT_W'(1));
  assign w_phase_nxt = r_dir ? r_phase + 2'd1 : r_phase - 2'd1;

  rate_div #(
    .DIV_W(DIV_W)
  ) u_rate_div (
    .clk     (cloc),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_period(period),
    .i_clr   (w_run && abort),
    .i_en    (w_run),
    .o_tc    (w_edge)
  );

  always_ff @(posedge cloc or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // An abort coinciding with a terminal count still lets that edge out (datapath below).
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_last || abort) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cloc or negedge rst_n) begin
    if (!rst_n) begin
      r_dir       <= 1'b0;
      r_remaining <= '0;
      r_pos       <= '0;
      r_phase     <= 2'd0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dir       <= dir;
        r_remaining <= steps;
      end
      if (w_edge) begin
        r_phase     <= w_phase_nxt;
        r_pos       <= r_dir ? r_pos + 1'b1 : r_pos - 1'b1;
        r_remaining <= r_remaining - 1'b1;
        {r_a, r_b}  <= PHASE_AB[w_phase_nxt];
      end
    end
  end

`ifdef ENC_INDEX_EN
  localparam int unsigned REV_W = (CPR > 1) ? $clog2(CPR) : 1;

  logic [REV_W-1:0] r_rev;
  logic [REV_W-1:0] w_rev_nxt;
  logic             r_z;

  always_comb begin
    w_rev_nxt = r_rev;
    if (r_dir) begin
      w_rev_nxt = (r_rev == REV_W'(CPR - 1)) ? '0 : r_rev + 1'b1;
    end else begin
      w_rev_nxt = (r_rev == '0) ? REV_W'(CPR - 1) : r_rev - 1'b1;
    end
  end

  // Index is computed from next-state values so it changes on the same edge as A/B.
  always_ff @(posedge cloc or negedge rst_n) begin
    if (!rst_n) begin
      r_rev <= '0;
      r_z   <= 1'b1;
    end else if (w_edge) begin
      r_rev <= w_rev_nxt;
      r_z   <= (w_rev_nxt == '0) && (w_phase_nxt == 2'd0);
    end
  end

  assign enc_z = r_z;
`endif

  assign busy  = w_run;
  assign done  = r_done;
  assign enc_a = r_a;
  assign enc_b = r_b;
  assign pos   = r_pos;

endmodule

// File: tb/tb_quad_enc_gen.sv
// Scoreboard bench for quad_enc_gen: driver pushes expected edge/done events, monitor pops on DUT activity.
module tb_quad_enc_gen;

  localparam int CPR_T = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [7:0]  steps = '0;
  logic [15:0] period = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        enc_a;
  logic        enc_b;
  logic [7:0]  pos;
`ifdef ENC_INDEX_EN
  logic        enc_z;
`endif

  quad_enc_gen #(
    .CNT_W(8),
    .DIV_W(16),
    .CPR  (CPR_T)
  ) dut (
    .cloc  (clk),
    .rst_n (rst_n),
    .start (start),
    .dir   (dir),
    .steps (steps),
    .period(period),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .pos   (pos)
`ifdef ENC_INDEX_EN
    ,
    .enc_z (enc_z)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         is_done;
    logic [1:0] ab;
    logic [7:0] pos;
    bit         busy;
    bit         z;
  } ev_t;

  ev_t        q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         m_edges = 0;
  bit         mon_en = 1'b0;
  logic [1:0] prev_ab = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] ab_of(input int e);
    int ph;
    ph = ((e % 4) + 4) % 4;
    case (ph)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic bit z_of(input int e);
    return (((e % CPR_T) + CPR_T) % CPR_T) == 0;
  endfunction

  function automatic ev_t mk_ev(input int c, input bit d, input bit b);
    ev_t e;
    e.cyc     = c;
    e.is_done = d;
    e.ab      = ab_of(m_edges);
    e.pos     = 8'(m_edges);
    e.busy    = b;
    e.z       = z_of(m_edges);
    return e;
  endfunction

  task automatic check_ev(input bit is_done_obs);
    ev_t e;
    bit  ok;
    bit  z_act;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event cyc=%0d done=%0b ab=%b pos=%02h: none expected", cyc, is_done_obs,
               {enc_a, enc_b}, pos);
      return;
    end
    e = q.pop_front();
`ifdef ENC_INDEX_EN
    z_act = enc_z;
`else
    z_act = e.z;
`endif
    ok = (e.is_done == is_done_obs) && (e.cyc == cyc) && (e.ab == {enc_a, enc_b}) &&
         (e.pos == pos) && (e.busy == busy) && (e.z == z_act);
    if (!ok) begin
      errors++;
      $display("FAIL event actual(done=%0b cyc=%0d ab=%b pos=%02h busy=%0b z=%0b) required(done=%0b cyc=%0d ab=%b pos=%02h busy=%0b z=%0b)",
               is_done_obs, cyc, {enc_a, enc_b}, pos, busy, z_act,
               e.is_done, e.cyc, e.ab, e.pos, e.busy, e.z);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if ({enc_a, enc_b} != prev_ab) begin
        check_ev(1'b0);
        prev_ab = {enc_a, enc_b};
      end
      if (done) check_ev(1'b1);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", name, act, req);
    end
  endtask

  // One move: model computes every edge and the done pulse up front, then drives the inputs.
  task automatic do_move(input bit d, input int n, input int p, input int abort_at, input bit hold,
                         input bit cont);
    int s, pe, ncnt, done_off;
    if (!cont) @(negedge clk);
    dir    = d;
    steps  = 8'(n);
    period = 16'(p);
    start  = 1'b1;
    s      = cyc + 1;
    if (n == 0) begin
      @(negedge clk);
      start = 1'b0;
      chk("busy_steps0", {7'd0, busy}, 8'd0);
      repeat (4) @(negedge clk);
      chk("busy_steps0_later", {7'd0, busy}, 8'd0);
      return;
    end
    pe = (p == 0) ? 1 : p;
    if (abort_at > 0 && abort_at < n * pe) begin
      ncnt     = abort_at / pe;
      done_off = abort_at;
    end else begin
      ncnt     = n;
      done_off = n * pe;
    end
    for (int i = 1; i <= ncnt; i++) begin
      m_edges += d ? 1 : -1;
      q.push_back(mk_ev(s + i * pe, 1'b0, (i * pe) != done_off));
    end
    q.push_back(mk_ev(s + done_off, 1'b1, 1'b0));

    @(negedge clk);
    chk("busy_after_start", {7'd0, busy}, 8'd1);
    if (!hold) start = 1'b0;
    while (cyc < s + done_off) begin
      abort = (abort_at > 0) && (cyc + 1 == s + abort_at);
      if (!hold) begin
        start  = ($urandom_range(0, 3) == 0);
        dir    = 1'($urandom_range(0, 1));
        steps  = 8'($urandom_range(1, 255));
        period = 16'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    abort = 1'b0;
    start = hold;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_a", {7'd0, enc_a}, 8'd0);
    chk("reset_b", {7'd0, enc_b}, 8'd0);
    chk("reset_pos", pos, 8'd0);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_done", {7'd0, done}, 8'd0);
`ifdef ENC_INDEX_EN
    chk("reset_z", {7'd0, enc_z}, 8'd1);
`endif
    rst_n  = 1'b1;
    mon_en = 1'b1;

    do_move(1'b1, 8, 4, 0, 1'b0, 1'b0);
    do_move(1'b0, 10, 1, 0, 1'b0, 1'b0);
    chk("pos_after_reverse", pos, 8'hFE);
    do_move(1'b1, 20, 3, 10, 1'b0, 1'b0);
    do_move(1'b0, 20, 3, 9, 1'b0, 1'b0);
    do_move(1'b1, 0, 2, 0, 1'b0, 1'b0);
    do_move(1'b1, 5, 0, 0, 1'b0, 1'b0);
    do_move(1'b0, 3, 2, 0, 1'b1, 1'b0);
    do_move(1'b0, 3, 2, 0, 1'b0, 1'b1);

`ifdef ENC_INDEX_EN
    do_move(1'b1, (CPR_T - (((m_edges % CPR_T) + CPR_T) % CPR_T)) % CPR_T, 1, 0, 1'b0, 1'b0);
    do_move(1'b1, 64, 1, 0, 1'b0, 1'b0);
    do_move(1'b0, 1, 1, 0, 1'b0, 1'b0);
    chk("z_after_reverse", {7'd0, enc_z}, 8'd0);
`endif

    for (int k = 0; k < 30; k++) begin
      int n, p, ab;
      n  = $urandom_range(0, 12);
      p  = $urandom_range(0, 5);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      do_move(1'($urandom_range(0, 1)), n, p, ab, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events actual=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
